// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Brief    : 4-digit multiplexed seven-segment scanner with frame-synchronous
//            double buffering and per-slot dead time.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
  parameter int PRESCALE = 1024,
  parameter int DEAD     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_blank,
  input  logic        i_load,
  output logic        o_pending,
  output logic [3:0]  o_nibble,
  output logic        o_dp,
  output logic [3:0]  o_digit,
  output logic        o_frame
);

  localparam int            CW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] c_last = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_act_data;
  logic [3:0]    r_act_dp;
  logic [3:0]    r_act_blank;
  logic [15:0]   r_sh_data;
  logic [3:0]    r_sh_dp;
  logic [3:0]    r_sh_blank;
  logic          r_pending;

  logic w_wrap;
  logic w_boundary;
  logic w_live;
  logic w_en;

  assign w_wrap     = (r_cnt == c_last);
  assign w_boundary = w_wrap && (r_idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The commit always takes the pre-edge shadow; a same-cycle load keeps pending set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_data   <= 16'h0000;
      r_sh_dp     <= 4'h0;
      r_sh_blank  <= 4'h0;
      r_act_data  <= 16'h0000;
      r_act_dp    <= 4'h0;
      r_act_blank <= 4'h0;
      r_pending   <= 1'b0;
    end else begin
      if (i_load) begin
        r_sh_data  <= i_data;
        r_sh_dp    <= i_dp;
        r_sh_blank <= i_blank;
      end
      if (w_boundary && r_pending) begin
        r_act_data  <= r_sh_data;
        r_act_dp    <= r_sh_dp;
        r_act_blank <= r_sh_blank;
      end
      if (i_load) begin
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  generate
    if (DEAD == 0) begin : g_no_dead
      assign w_live = 1'b1;
    end else begin : g_dead
      localparam logic [CW-1:0] c_dead = CW'(DEAD);
      assign w_live = (r_cnt >= c_dead);
    end
  endgenerate

  assign w_en      = w_live && !r_act_blank[r_idx];
  assign o_digit   = w_en ? (4'b0001 << r_idx) : 4'b0000;
  assign o_dp      = w_en && r_act_dp[r_idx];
  assign o_nibble  = r_act_data[{r_idx, 2'b00} +: 4];
  assign o_frame   = (r_idx == 2'd0) && (r_cnt == '0);
  assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scanner
// Brief    : Directed vector bench for seven_segment_scanner (PRESCALE=8, DEAD=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_data = 16'h0000;
  logic [3:0]  i_dp = 4'h0;
  logic [3:0]  i_blank = 4'h0;
  logic        i_load = 1'b0;
  logic        o_pending;
  logic [3:0]  o_nibble;
  logic        o_dp;
  logic [3:0]  o_digit;
  logic        o_frame;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  seven_segment_scanner #(.PRESCALE(8), .DEAD(2)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_dp(i_dp), .i_blank(i_blank),
    .i_load(i_load), .o_pending(o_pending), .o_nibble(o_nibble), .o_dp(o_dp),
    .o_digit(o_digit), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  // seq: displayed nibbles in idx order 0,1,2,3 (MSB first); dig: enabled o_digit
  // per idx in the same order; dpx: o_dp per idx (bit3 = idx0).
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [15:0] seq;
    logic [15:0] dig;
    logic [3:0]  dpx;
  } vec_t;

  vec_t vecs [4];
  vec_t idle;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got=%h want=%h", name, k, got, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    k++;
  endtask

  task automatic goto_phase(input int ph);
    while ((k % 32) != ph) adv();
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    i_data = d; i_dp = p; i_blank = b; i_load = 1'b1;
    adv();
    i_load = 1'b0;
  endtask

  // Checks one full frame starting at its o_frame cycle; ends on the next frame's first cycle.
  task automatic check_frame(input vec_t v, input logic pend);
    for (int c = 0; c < 32; c++) begin
      int ix;
      int cy;
      logic [15:0] s;
      logic [15:0] d;
      logic [3:0]  edig;
      logic        edp;
      ix = c / 8;
      cy = c % 8;
      s = v.seq;
      d = v.dig;
      edig = (cy >= 2) ? d[15-4*ix -: 4] : 4'h0;
      edp  = (cy >= 2) ? v.dpx[3-ix] : 1'b0;
      chk("nibble",  {12'h0, o_nibble}, {12'h0, s[15-4*ix -: 4]});
      chk("digit",   {12'h0, o_digit}, {12'h0, edig});
      chk("dp",      {15'h0, o_dp}, {15'h0, edp});
      chk("frame",   {15'h0, o_frame}, {15'h0, (c == 0)});
      chk("pending", {15'h0, o_pending}, {15'h0, pend});
      adv();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog k=%0d got=timeout want=finish", k);
    $fatal(1);
  end

  initial begin
    logic [15:0] cur;
    logic [15:0] s;
    idle    = '{data:16'h0000, dp:4'h0, blank:4'h0, seq:16'h0000, dig:16'h1248, dpx:4'b0000};
    vecs[0] = '{data:16'h1234, dp:4'b0100, blank:4'h0, seq:16'h4321, dig:16'h1248, dpx:4'b0010};
    vecs[1] = '{data:16'hBEEF, dp:4'b1111, blank:4'b1010, seq:16'hFEEB, dig:16'h1040, dpx:4'b1010};
    vecs[2] = '{data:16'hC0DE, dp:4'b1001, blank:4'h0, seq:16'hED0C, dig:16'h1248, dpx:4'b1001};
    vecs[3] = '{data:16'h0000, dp:4'h0, blank:4'h0, seq:16'h0000, dig:16'h1248, dpx:4'b0000};

    repeat (3) @(negedge clk);
    chk("rst_digit",   {12'h0, o_digit}, 16'h0);
    chk("rst_pending", {15'h0, o_pending}, 16'h0);
    chk("rst_frame",   {15'h0, o_frame}, 16'h1);
    chk("rst_nibble",  {12'h0, o_nibble}, 16'h0);
    rst = 1'b0;
    k = 0;

    check_frame(idle, 1'b0);
    check_frame(idle, 1'b0);
    cur = idle.seq;

    // Deferred loads: old data keeps showing until the boundary.
    for (int i = 0; i < 4; i++) begin
      goto_phase(10);
      load(vecs[i].data, vecs[i].dp, vecs[i].blank);
      while ((k % 32) != 0) begin
        s = cur;
        chk("wait_pending", {15'h0, o_pending}, 16'h1);
        chk("wait_nibble", {12'h0, o_nibble}, {12'h0, s[15-4*((k%32)/8) -: 4]});
        adv();
      end
      check_frame(vecs[i], 1'b0);
      cur = vecs[i].seq;
    end

    // Back-to-back loads: last one wins.
    goto_phase(5);
    load(16'h0001, 4'h0, 4'h0);
    load(16'h0002, 4'h0, 4'h0);
    load(16'h0003, 4'h0, 4'h0);
    goto_phase(0);
    check_frame('{data:16'h0003, dp:4'h0, blank:4'h0, seq:16'h3000, dig:16'h1248, dpx:4'b0000}, 1'b0);

    // Load on the boundary cycle while the shadow already holds pending data.
    goto_phase(12);
    load(16'h5555, 4'h0, 4'h0);
    goto_phase(31);
    chk("coll_pre_pending", {15'h0, o_pending}, 16'h1);
    load(16'hAAAA, 4'h0, 4'h0);
    check_frame('{data:16'h5555, dp:4'h0, blank:4'h0, seq:16'h5555, dig:16'h1248, dpx:4'b0000}, 1'b1);
    check_frame('{data:16'hAAAA, dp:4'h0, blank:4'h0, seq:16'hAAAA, dig:16'h1248, dpx:4'b0000}, 1'b0);

    // Asynchronous reset mid-slot of digit 2 with pending data.
    goto_phase(19);
    load(16'h9876, 4'b1111, 4'h0);
    chk("pre_rst_digit",   {12'h0, o_digit}, 16'h4);
    chk("pre_rst_pending", {15'h0, o_pending}, 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_digit",   {12'h0, o_digit}, 16'h0);
    chk("arst_nibble",  {12'h0, o_nibble}, 16'h0);
    chk("arst_dp",      {15'h0, o_dp}, 16'h0);
    chk("arst_frame",   {15'h0, o_frame}, 16'h1);
    chk("arst_pending", {15'h0, o_pending}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    check_frame(idle, 1'b0);
    check_frame(idle, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
